mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4: fixed memory read latency in cycles, from read issue to data on mem_rdata.
REQ-002 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block fill; fixed at 8 in this revision.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  1  instruction-cache block fill request.
REQ-006 i_addr  in  16  instruction fill byte address; low 4 bits ignored.
REQ-007 d_req  in  1  data-side request, either a fill or a write.
REQ-008 d_we  in  1  data-side type; 1 = single-word write, 0 = block fill.
REQ-009 d_addr  in  16  data byte address.
REQ-010 d_wdata  in  16  data-side write data.
REQ-011 mem_en  out  1  memory access this cycle.
REQ-012 mem_wr  out  1  memory access is a write.
REQ-013 mem_addr  out  16  memory byte address.
REQ-014 mem_wdata  out  16  memory write data.
REQ-015 mem_rdata  in  16  memory read data, valid MEM_LAT cycles after read issue.
REQ-016 i_fill_valid / d_fill_valid  out  1 each  fill word presented to the owning requester.
REQ-017 fill_word  out  3  index of the presented word within the block.
REQ-018 fill_data  out  16  presented word.
REQ-019 i_done / d_done  out  1 each  one-cycle transaction-complete pulse.
REQ-020 busy  out  1  high when the state is not IDLE.

Function
REQ-021 The arbiter SHALL implement the FSM states IDLE, I_FILL, D_FILL and D_WRITE.
REQ-022 Requests SHALL be sampled only in IDLE; grant takes effect at the next edge.
- I alone -> I_FILL.
- D alone -> D_FILL if d_we=0, D_WRITE if d_we=1.
REQ-023 If both sides request in IDLE, the grant SHALL go opposite to last_grant.
- last_grant is a 1-bit register updated on every grant.
- last_grant resets to I, so D wins the first tie.
REQ-024 Fill request address and d_we SHALL be latched at grant; later changes to i_addr, d_addr, d_we or d_wdata are ignored.
REQ-025 Fill timing: let cycle T be the first cycle in the fill state.
- Issue: cycle T+k, k=0..7 -> mem_en=1, mem_wr=0, mem_addr=(addr & 0xFFF0)+2k.
REQ-026 Fill return timing (same T):
- Cycle T+k+MEM_LAT -> owner's fill_valid=1, fill_word=k, fill_data=mem_rdata.
- Reads are pipelined; the issue and return counters are independent 3-bit counters.
REQ-027 The owner's done SHALL pulse together with word 7 at T+7+MEM_LAT; the next cycle the state SHALL be IDLE.
- A fill is 8+MEM_LAT cycles, 12 at default.
REQ-028 D_WRITE SHALL last one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1, then return to IDLE.
REQ-029 The minimum gap between transactions SHALL be one IDLE cycle after done.
- Requesters deassert req at the edge following done.
- req high in IDLE is a new request.
REQ-030 Deasserting req mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-031 Only the owning side's fill_valid and done may assert; the other side's are 0.
REQ-032 When mem_en=0, mem_wr, mem_addr and mem_wdata SHALL be 0.
REQ-033 When no fill_valid is high, fill_word and fill_data SHALL be 0.

Reset
REQ-034 With rst_n=0 at an edge, the arbiter SHALL set:
- state=IDLE, last_grant=I, counters=0;
- all outputs 0 from the following cycle.
REQ-035 Reset mid-fill SHALL discard in-flight reads; returns arriving after reset produce no fill_valid.
REQ-036 After release, the first arbitration SHALL occur in the first cycle with rst_n=1.

Verification
REQ-037 i_req alone, i_addr=0x0024, MEM_LAT=4 -> mem_addr 0x0020,0x0022..0x002E in T..T+7; i_fill_valid words 0..7 in T+4..T+11; i_done at T+11; busy low at T+12.
REQ-038 i_req and d_req(d_we=0, d_addr=0x4008) together after reset -> D_FILL first (addr 0x4000..0x400E); I_FILL starts 1 IDLE cycle after d_done.
REQ-039 d_req, d_we=1, d_addr=0x1002, d_wdata=0xBEEF -> one cycle mem_en=1, mem_wr=1, mem_addr=0x1002, mem_wdata=0xBEEF, d_done=1; all memory outputs 0 next cycle.
REQ-040 rst_n=0 during issue k=3 of an I fill, returned data 0xAAAA thereafter -> busy=0, no i_fill_valid, no i_done; a new i_req after release restarts at word 0.
REQ-041 i_req and d_req both held continuously -> grants alternate D, I, D, I, each separated by one IDLE cycle.
REQ-042 i_req dropped at T+2 of an I fill -> all 8 words still returned, i_done at T+11.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between an instruction-cache
// fill requester and a data-side requester (block fill or single-word write).
// Fills issue eight sequential reads and forward each word MEM_LAT cycles later.
// A tie in IDLE is granted opposite to the previous grant.
module mem_arbiter #(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] I_FILL  = 2'd1;
  localparam logic [1:0] D_FILL  = 2'd2;
  localparam logic [1:0] D_WRITE = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  logic [1:0]         state;
  logic               lastGrant;
  logic [15:0]        xferAddr;
  logic [15:0]        xferWdata;
  logic [2:0]         issueCnt;
  logic [2:0]         retCnt;
  logic               issueDone;
  logic [MEM_LAT-1:0] readPipe;

  logic inFill;
  logic issuing;
  logic retValid;
  logic lastRet;

  // A read is issued every fill cycle until all words have gone out; the
  // delay line marks which cycles carry a returning word.
  assign inFill   = (state == I_FILL) || (state == D_FILL);
  assign issuing  = inFill && !issueDone;
  assign retValid = inFill && readPipe[MEM_LAT-1];
  assign lastRet  = retValid && (retCnt == LAST_WORD);

  // Arbitration in IDLE, request latching at grant, and return to IDLE on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lastGrant <= GRANT_I;
      xferAddr  <= '0;
      xferWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || lastGrant == GRANT_D)) begin
            state     <= I_FILL;
            lastGrant <= GRANT_I;
            xferAddr  <= i_addr;
            xferWdata <= '0;
          end else if (d_req) begin
            state     <= d_we ? D_WRITE : D_FILL;
            lastGrant <= GRANT_D;
            xferAddr  <= d_addr;
            xferWdata <= d_wdata;
          end
        end
        I_FILL, D_FILL: begin
          if (lastRet) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Independent issue and return word counters; both restart whenever the arbiter is idle.
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      issueCnt  <= '0;
      retCnt    <= '0;
      issueDone <= 1'b0;
    end else begin
      if (issuing) begin
        issueCnt <= issueCnt + 3'd1;
        if (issueCnt == LAST_WORD) begin
          issueDone <= 1'b1;
        end
      end
      if (retValid) begin
        retCnt <= retCnt + 3'd1;
      end
    end
  end

  // Delay line tracking outstanding reads; reset flushes reads still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readPipe <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        readPipe[i] <= readPipe[i-1];
      end
      readPipe[0] <= issuing;
    end
  end

  // Output decode; every field is forced to zero when its qualifier is low.
  always_comb begin
    mem_en       = issuing || (state == D_WRITE);
    mem_wr       = (state == D_WRITE);
    mem_addr     = '0;
    mem_wdata    = '0;
    if (issuing) begin
      mem_addr = {xferAddr[15:4], issueCnt, 1'b0};
    end else if (state == D_WRITE) begin
      mem_addr  = xferAddr;
      mem_wdata = xferWdata;
    end
    i_fill_valid = retValid && (state == I_FILL);
    d_fill_valid = retValid && (state == D_FILL);
    fill_word    = retValid ? retCnt : 3'd0;
    fill_data    = retValid ? mem_rdata : 16'd0;
    i_done       = lastRet && (state == I_FILL);
    d_done       = (lastRet && (state == D_FILL)) || (state == D_WRITE);
    busy         = (state != IDLE);
  end

endmodule
